// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing generator (coordinates, enable, syncs, strobes)
// Optional macro VGA_TIMING_SYNC_DELAY_EN delays HSync/VSync by SYNC_DELAY master clocks.
module vga_timing_gen #(
  parameter int   CLK_DIV    = 4,
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   SYNC_DELAY = 1
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  output logic       Pixel_Tick_Out,
  output logic [9:0] Val_Row_Out,
  output logic [9:0] Val_Col_Out,
  output logic       Disp_Ena_Out,
  output logic       HSync_Out,
  output logic       VSync_Out,
  output logic       Frame_Start_Out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (CLK_DIV < 1 || SYNC_DELAY < 1) begin : g_bad_param
    $error("vga_timing_gen: CLK_DIV and SYNC_DELAY must be at least 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [9:0]       row_q, row_d, col_q, col_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             pt_q, pt_d, fs_q, fs_d;
  logic             tick;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    row_d = row_q;
    col_d = col_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    pt_d  = tick;
    fs_d  = 1'b0;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Every registered output is decoded from the new position, not the old one.
      row_d = h_d;
      col_d = v_d;
      de_d  = (h_d < H_VIS) && (v_d < V_VIS);
      hs_d  = (h_d >= HS_FIRST && h_d <= HS_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d  = (v_d >= VS_FIRST && v_d <= VS_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
      fs_d  = (h_d == '0) && (v_d == '0);
    end
  end

  // Counters reset to the last position so the first tick lands on (0,0).
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      div_q <= '0;
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      row_q <= '0;
      col_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~H_SYNC_POL;
      vs_q  <= ~V_SYNC_POL;
      pt_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      row_q <= row_d;
      col_q <= col_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      pt_q  <= pt_d;
      fs_q  <= fs_d;
    end
  end

`ifdef VGA_TIMING_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

  always_comb begin
    hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hs_q});
    vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vs_q});
  end

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      hs_pipe_q <= {SYNC_DELAY{~H_SYNC_POL}};
      vs_pipe_q <= {SYNC_DELAY{~V_SYNC_POL}};
    end else begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign HSync_Out = hs_pipe_q[SYNC_DELAY-1];
  assign VSync_Out = vs_pipe_q[SYNC_DELAY-1];
`else
  assign HSync_Out = hs_q;
  assign VSync_Out = vs_q;
`endif

  assign Pixel_Tick_Out  = pt_q;
  assign Val_Row_Out     = row_q;
  assign Val_Col_Out     = col_q;
  assign Disp_Ena_Out    = de_q;
  assign Frame_Start_Out = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: full-size line timing plus a shrunken raster for frame timing
// Honours VGA_TIMING_SYNC_DELAY_EN (syncs checked one master clock after the tick).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       d_pt, d_de, d_hs, d_vs, d_fs;
  logic [9:0] d_row, d_col;
  logic       s_pt, s_de, s_hs, s_vs, s_fs;
  logic [9:0] s_row, s_col;

  vga_timing_gen u_dut (
    .Master_Clock_In (clk),
    .Reset_N_In      (rst_n),
    .Pixel_Tick_Out  (d_pt),
    .Val_Row_Out     (d_row),
    .Val_Col_Out     (d_col),
    .Disp_Ena_Out    (d_de),
    .HSync_Out       (d_hs),
    .VSync_Out       (d_vs),
    .Frame_Start_Out (d_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_small (
    .Master_Clock_In (clk),
    .Reset_N_In      (rst_n),
    .Pixel_Tick_Out  (s_pt),
    .Val_Row_Out     (s_row),
    .Val_Col_Out     (s_col),
    .Disp_Ena_Out    (s_de),
    .HSync_Out       (s_hs),
    .VSync_Out       (s_vs),
    .Frame_Start_Out (s_fs)
  );

  // Vector layout: {row[9:0], col[9:0], de, hs, vs, fs, pt}
  logic [24:0] d_vec, s_vec;
  assign d_vec = {d_row, d_col, d_de, d_hs, d_vs, d_fs, d_pt};
  assign s_vec = {s_row, s_col, s_de, s_hs, s_vs, s_fs, s_pt};

  localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  int n_cmp = 0;
  int n_bad = 0;
  int last_cyc;
  int last_fs_cyc;
  logic [24:0] q_exp[$];

  // Expected outputs after the k-th tick since reset, from the raster index directly.
  function automatic logic [24:0] model(input int k, input int hv, input int hf, input int hsw,
                                        input int hb, input int vv, input int vf, input int vsw,
                                        input int vb);
    int ht, vt, h, v;
    logic de, hs, vs, fs;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    de = (h < hv) && (v < vv);
    hs = !((h >= hv + hf) && (h < hv + hf + hsw));
    vs = !((v >= vv + vf) && (v < vv + vf + vsw));
    fs = (h == 0) && (v == 0);
    return {10'(h), 10'(v), de, hs, vs, fs, 1'b1};
  endfunction

  task automatic check_vec(input string tag, input logic [24:0] o, input logic [24:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (row/col/de/hs/vs/fs/pt)", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    last_cyc = cyc;
    last_fs_cyc = -1;
  endtask

  task automatic assert_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_vec({tag, "_big"}, d_vec, RST_VEC);
    check_vec({tag, "_small"}, s_vec, RST_VEC);
  endtask

  task automatic run(input int which, input int k0, input int n);
    logic [24:0] e, o;
    bit got;
    for (int i = 0; i < n; i++) begin
      e = which ? model(k0 + i, 8, 2, 3, 3, 6, 1, 2, 2)
                : model(k0 + i, 640, 16, 96, 48, 480, 10, 2, 33);
      q_exp.push_back(e);
      got = 1'b0;
      for (int w = 0; w < 16 && !got; w++) begin
        @(posedge clk);
        #1;
        got = which ? s_pt : d_pt;
      end
      e = q_exp.pop_front();
      n_cmp++;
      assert (got) else begin
        n_bad++;
        $error("FAIL tick_timeout observed=none expected=tick k=%0d", k0 + i);
        return;
      end
      o = which ? s_vec : d_vec;
`ifdef VGA_TIMING_SYNC_DELAY_EN
      check_vec($sformatf("tick%0d_k%0d", which, k0 + i), {o[24:4], 2'b00, o[1:0]},
                {e[24:4], 2'b00, e[1:0]});
`else
      check_vec($sformatf("tick%0d_k%0d", which, k0 + i), o, e);
`endif
      check_int("tick_spacing", cyc - last_cyc, which ? 2 : 4);
      last_cyc = cyc;
      if (e[1]) begin
        if (last_fs_cyc >= 0)
          check_int("frame_period", cyc - last_fs_cyc, which ? 352 : 1680000);
        last_fs_cyc = cyc;
      end
`ifdef VGA_TIMING_SYNC_DELAY_EN
      @(posedge clk);
      #1;
      o = which ? s_vec : d_vec;
      check_int("delayed_syncs", int'(o[3:2]), int'(e[3:2]));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_vec("reset_big", d_vec, RST_VEC);
    check_vec("reset_small", s_vec, RST_VEC);

    // Full-size raster: first tick, whole line 0 and the wrap into line 1.
    release_reset();
    run(0, 0, 801);

    assert_reset("reset_again");
    repeat (3) @(posedge clk);

    // Shrunken raster: two full frames, then stop mid-frame at (5,3).
    release_reset();
    run(1, 0, 353);
    run(1, 353, 53);
    assert_reset("midframe_reset");
    repeat (2) @(posedge clk);
    #1;
    check_vec("midframe_hold", s_vec, RST_VEC);
    release_reset();
    run(1, 0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
